multicycle_ctrl: RTL and testbench

- Control FSM that sequences the multicycle MIPS-subset datapath that runs the factorial program.
- Decodes the registered opcode and drives every datapath enable and mux select.
- Waits on a ready/valid-style handshake with unified instruction/data memory.
- Flags illegal opcodes and memory timeouts.
- Sits between the datapath core and the memory wrapper; the top level instantiates it next to the datapath.

---
 rtl/ctrl_pkg.sv | 52 +++++
 rtl/ctrl_next_state.sv | 69 ++++++
 rtl/multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle MIPS-subset control unit:
//   - state_t      : FSM state encoding (also visible on the state port)
//   - OP_*         : opcode field values of the supported instructions
//   - SRCB_*       : ALU B operand mux encodings
//   - ALUOP_*      : ALU control class encodings
//   - PCSRC_*      : PC source mux encodings
//   - is_mem_state : states that hold a memory request open
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_SE   = 2'b10;
    localparam logic [1:0] SRCB_SESH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/ctrl_next_state.sv
// ---------------------------------------------------------------------------
// ctrl_next_state
// Combinational next-state logic of the multicycle control FSM.
// Ports:
//   i_state      : current state
//   i_opcode     : registered instruction opcode field
//   i_mem_ready  : memory completes the current access this cycle
//   i_timeout    : wait limit reached in a memory state with no ready
//   o_next       : next state
//   o_illegal_op : DECODE sees an unsupported opcode (valid only in DECODE)
// ---------------------------------------------------------------------------
module ctrl_next_state
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  state_t              i_state,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_mem_ready,
    input  logic                i_timeout,
    output state_t              o_next,
    output logic                o_illegal_op
);

    always_comb begin
        o_next       = i_state;
        o_illegal_op = 1'b0;
        case (i_state)
            S_FETCH: begin
                if (i_timeout)        o_next = S_FETCH;
                else if (i_mem_ready) o_next = S_DECODE;
            end
            S_DECODE: begin
                case (i_opcode)
                    OPCODE_W'(OP_RTYPE): o_next = S_EXEC;
                    OPCODE_W'(OP_LW),
                    OPCODE_W'(OP_SW):    o_next = S_MEMADR;
                    OPCODE_W'(OP_BEQ):   o_next = S_BRANCH;
                    OPCODE_W'(OP_ADDI):  o_next = S_ADDIEX;
                    OPCODE_W'(OP_J):     o_next = S_JUMP;
                    default: begin
                        // PC was already bumped in FETCH, so skipping is just
                        // a return to FETCH.
                        o_next       = S_FETCH;
                        o_illegal_op = 1'b1;
                    end
                endcase
            end
            // Only lw and sw reach MEMADR, so anything not sw is a load.
            S_MEMADR: o_next = (i_opcode == OPCODE_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (i_timeout)        o_next = S_FETCH;
                else if (i_mem_ready) o_next = S_MEMWB;
            end
            S_MEMWB: o_next = S_FETCH;
            S_MEMWR: begin
                if (i_timeout || i_mem_ready) o_next = S_FETCH;
            end
            S_EXEC:   o_next = S_ALUWB;
            S_ALUWB:  o_next = S_FETCH;
            S_BRANCH: o_next = S_FETCH;
            S_JUMP:   o_next = S_FETCH;
            S_ADDIEX: o_next = S_ADDIWB;
            S_ADDIWB: o_next = S_FETCH;
            default:  o_next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for the multicycle MIPS-subset datapath (lw, sw, R-type, beq,
// addi, j). Moore decode of state drives all datapath enables and mux
// selects; only ir_write/pc_en in FETCH follow mem_ready directly.
// A wait counter aborts any memory state that sees no mem_ready for
// MEM_WAIT_MAX consecutive cycles.
//
// Optional feature macro: CTRL_PERF_CNT_EN adds cycle_cnt / instr_cnt.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   opcode                : IR[31:26]
//   zero                  : ALU zero flag (beq)
//   mem_ready             : memory handshake completion
//   iord, mem_read,
//   mem_write             : memory address select and request strobes
//   ir_write, pc_en       : IR / PC load enables
//   reg_dst, mem_to_reg,
//   reg_write             : register file write controls
//   alu_src_a, alu_src_b,
//   alu_op, pc_src        : ALU operand / operation and PC source selects
//   illegal, mem_timeout  : sticky error flags
//   cycle_cnt, instr_cnt  : performance counters (macro only)
//   state                 : current FSM state
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 6,
    parameter int STATE_W      = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic                pc_en,
    output logic                illegal,
    output logic                mem_timeout,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instr_cnt,
`endif
    output logic [STATE_W-1:0]  state
);

    localparam int WCNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_illegal_op;
    logic              w_mem_state;
    logic              w_timeout;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_illegal;
    logic              r_mem_timeout;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    ctrl_next_state #(
        .OPCODE_W (OPCODE_W)
    ) u_next (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_mem_ready  (mem_ready),
        .i_timeout    (w_timeout),
        .o_next       (w_next),
        .o_illegal_op (w_illegal_op)
    );

    // -----------------------------------------------------------------------
    // Memory wait supervision
    // The counter holds the number of stalled cycles already spent in the
    // current memory state, so the MEM_WAIT_MAX-th stalled cycle is the one
    // that aborts. A ready on that same cycle still completes normally.
    // -----------------------------------------------------------------------
    assign w_mem_state = is_mem_state(r_state);
    assign w_timeout   = w_mem_state && !mem_ready &&
                         (r_wait_cnt == WCNT_W'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (mem_ready || w_timeout || !w_mem_state || (w_next != r_state)) begin
            // Leaving a state (or not being in a memory state) guarantees the
            // count starts at zero on entry to FETCH/MEMRD/MEMWR.
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State register and sticky flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_illegal     <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_DECODE) && w_illegal_op) r_illegal     <= 1'b1;
            if (w_timeout)                             r_mem_timeout <= 1'b1;
        end
    end

    assign illegal     = r_illegal;
    assign mem_timeout = r_mem_timeout;
    assign state       = STATE_W'(r_state);

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        pc_en      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_b = SRCB_SESH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SE;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_en     = zero;
            end
            S_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_en  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SE;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
        // A reset cycle abandons the instruction: suppress every write.
        if (reset) begin
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef CTRL_PERF_CNT_EN
    logic        w_instr_done;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    // Any return to FETCH from a state past DECODE that is not a timeout is
    // a completed instruction; illegal opcodes return from DECODE itself.
    assign w_instr_done = (w_next == S_FETCH) && (r_state != S_FETCH) &&
                          (r_state != S_DECODE) && !w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_instr_done) r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl: lw/sw/beq/addi/R-type/j sequences,
// illegal opcode, FETCH stall with ready on the limit cycle, timeout, and
// reset during a stall. Counters are checked when CTRL_PERF_CNT_EN is set.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic        reg_write, alu_src_a, pc_en, illegal, mem_timeout;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_ctrl #(
        .OPCODE_W     (6),
        .STATE_W      (4),
        .MEM_WAIT_MAX (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .illegal     (illegal),
        .mem_timeout (mem_timeout),
`ifdef CTRL_PERF_CNT_EN
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt),
`endif
        .state       (state)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int pe_cnt, rw_cnt, mw_cnt;
    int lw_seq[5] = '{0, 1, 2, 3, 4};
    int sw_seq[7] = '{0, 1, 2, 5, 5, 5, 5};
    logic [5:0] prog_op[5];
    logic       prog_z[5];
    int         prog_lat[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let inputs settle, then check the state.
    task automatic step(input string tag, input int exp_st);
        #2;
        chk(tag, {28'd0, state}, exp_st);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        tick(); tick();
        #2;
        chk("reset state", {28'd0, state}, 0);
        chk("reset illegal", {31'd0, illegal}, 0);
        chk("reset timeout", {31'd0, mem_timeout}, 0);

        // ---------------- lw, no waits ----------------
        reset = 1'b0; opcode = OP_LW; mem_ready = 1'b1;
        pe_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step("lw state", lw_seq[i]);
            pe_cnt += int'(pc_en);
            chk("lw reg_write", {31'd0, reg_write}, (lw_seq[i] == 4) ? 1 : 0);
            tick();
        end
        step("lw done", 0);
        chk("lw pc_en count", pe_cnt, 1);

        // ---------------- sw, 3 wait cycles ----------------
        opcode = OP_SW;
        mw_cnt = 0; rw_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            step("sw state", sw_seq[i]);
            mw_cnt += int'(mem_write);
            rw_cnt += int'(reg_write);
            tick();
        end
        mem_ready = 1'b1;
        step("sw done", 0);
        chk("sw mem_write cycles", mw_cnt, 4);
        chk("sw reg_write cycles", rw_cnt, 0);

        // ---------------- beq taken / not taken ----------------
        opcode = OP_BEQ; zero = 1'b1;
        tick(); step("beq1 decode", 1);
        chk("decode alu_src_b", {30'd0, alu_src_b}, 32'h3);
        tick(); step("beq1 branch", 8);
        chk("beq1 pc_en", {31'd0, pc_en}, 1);
        chk("beq1 pc_src", {30'd0, pc_src}, 32'h1);
        chk("beq1 alu_op", {30'd0, alu_op}, 32'h1);
        tick(); step("beq1 done", 0);
        zero = 1'b0;
        tick(); step("beq2 decode", 1);
        tick(); step("beq2 branch", 8);
        chk("beq2 pc_en", {31'd0, pc_en}, 0);
        tick(); step("beq2 done", 0);

        // ---------------- illegal opcode then addi ----------------
        opcode = 6'b111111;
        tick(); step("ill decode", 1);
        chk("ill before", {31'd0, illegal}, 0);
        tick(); step("ill fetch", 0);
        chk("ill flag", {31'd0, illegal}, 1);
        opcode = OP_ADDI;
        tick(); step("addi decode", 1);
        tick(); step("addi ex", 10);
        chk("addi alu_src_b", {30'd0, alu_src_b}, 32'h2);
        tick(); step("addi wb", 11);
        chk("addi reg_write", {31'd0, reg_write}, 1);
        chk("addi reg_dst", {31'd0, reg_dst}, 0);
        tick(); step("addi done", 0);
        chk("ill sticky", {31'd0, illegal}, 1);

        // ---------------- R-type ----------------
        opcode = OP_RTYPE;
        tick(); step("r decode", 1);
        tick(); step("r exec", 6);
        chk("r alu_op", {30'd0, alu_op}, 32'h2);
        tick(); step("r wb", 7);
        chk("r reg_dst", {31'd0, reg_dst}, 1);
        chk("r reg_write", {31'd0, reg_write}, 1);
        tick(); step("r done", 0);

        // ---------------- FETCH stall, ready on limit cycle ----------------
        opcode = OP_J; mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step("lim stall", 0);
            if (i == 0) chk("lim ir_write", {31'd0, ir_write}, 0);
            tick();
        end
        mem_ready = 1'b1;
        step("lim last", 0);
        chk("lim pc_en", {31'd0, pc_en}, 1);
        tick(); step("lim decode", 1);
        chk("lim no timeout", {31'd0, mem_timeout}, 0);
        tick(); step("j state", 9);
        chk("j pc_en", {31'd0, pc_en}, 1);
        chk("j pc_src", {30'd0, pc_src}, 32'h2);
        tick(); step("j done", 0);

        // ---------------- FETCH timeout ----------------
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step("to stall", 0);
            tick();
        end
        step("to cycle15", 0);
        chk("to not yet", {31'd0, mem_timeout}, 0);
        tick(); step("to fetch", 0);
        chk("to flag", {31'd0, mem_timeout}, 1);
        chk("to pc_en", {31'd0, pc_en}, 0);
        // second stall, reset on its 7th cycle
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        step("rst cycle7", 0);
        chk("rst flag held", {31'd0, mem_timeout}, 1);
        tick(); step("rst state", 0);
        chk("rst timeout", {31'd0, mem_timeout}, 0);
        chk("rst illegal", {31'd0, illegal}, 0);

`ifdef CTRL_PERF_CNT_EN
        // ---------------- performance counters ----------------
        prog_op[0] = OP_RTYPE; prog_z[0] = 1'b0; prog_lat[0] = 4;
        prog_op[1] = OP_ADDI;  prog_z[1] = 1'b0; prog_lat[1] = 4;
        prog_op[2] = OP_BEQ;   prog_z[2] = 1'b0; prog_lat[2] = 3;
        prog_op[3] = OP_BEQ;   prog_z[3] = 1'b1; prog_lat[3] = 3;
        prog_op[4] = OP_J;     prog_z[4] = 1'b0; prog_lat[4] = 3;
        chk("perf cyc reset", cycle_cnt, 0);
        chk("perf ins reset", instr_cnt, 0);
        reset = 1'b0; mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            opcode = prog_op[k]; zero = prog_z[k];
            for (int c = 0; c < prog_lat[k]; c++) tick();
            step("perf fetch", 0);
        end
        chk("perf cycle_cnt", cycle_cnt, 17);
        chk("perf instr_cnt", instr_cnt, 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
